// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle: ALU result path, LSU result stream,
// hazard lookup ports and the registered register-file write port.
interface wb_arbiter_if;
    // ALU result path (single cycle, stalled only by alu_stall)
    logic        alu_valid;
    logic [5:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_stall;

    // LSU result stream (valid/ready into the result FIFO)
    logic        lsu_valid;
    logic        lsu_ready;
    logic [5:0]  lsu_addr;
    logic [31:0] lsu_data;

    // Issue-stage hazard lookups
    logic [5:0]  rs1_addr;
    logic [5:0]  rs2_addr;
    logic [5:0]  rd_addr;
    logic        rs1_pending;
    logic        rs2_pending;
    logic        rd_pending;

    // Register-file write port
    logic        wb_en;
    logic [5:0]  wb_addr;
    logic [31:0] write_data;

    // Upstream side: pipeline stages feeding results and doing lookups
    modport master (
        output alu_valid, alu_addr, alu_data,
        output lsu_valid, lsu_addr, lsu_data,
        output rs1_addr, rs2_addr, rd_addr,
        input  alu_stall, lsu_ready,
        input  rs1_pending, rs2_pending, rd_pending,
        input  wb_en, wb_addr, write_data
    );

    // Arbiter side
    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  lsu_valid, lsu_addr, lsu_data,
        input  rs1_addr, rs2_addr, rd_addr,
        output alu_stall, lsu_ready,
        output rs1_pending, rs2_pending, rd_pending,
        output wb_en, wb_addr, write_data
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges a priority ALU result path with a FIFO-buffered
// LSU result stream into one registered register-file write per cycle.
// A starvation counter forces a FIFO drain slot after STARVE_LIMIT
// consecutive ALU wins, and pending flags expose queued/in-flight writes
// to the issue stage for RAW/WAW stalls.
module wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // FIFO storage; occupancy is tracked by per-entry valid bits and a count
    logic [5:0]       mem_addr_q [DEPTH];
    logic [31:0]      mem_data_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Starvation tracking
    logic [3:0]       starve_q, starve_d;
    logic             stall_q, stall_d;

    // Output register
    logic             wb_en_q, wb_en_d;
    logic [5:0]       wb_addr_q, wb_addr_d;
    logic [31:0]      wb_data_q, wb_data_d;

    // Per-cycle decisions
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             alu_win;
    logic [5:0]       head_addr;
    logic [31:0]      head_data;

    logic             rs1_hit, rs2_hit, rd_hit;

    // Arbitration: ALU has priority unless the forced drain slot is active;
    // any cycle the ALU does not write is offered to the FIFO head.
    always_comb begin
        fifo_empty = (cnt_q == '0);
        fifo_full  = (cnt_q == CNT_W'(DEPTH));
        // x0 results complete the handshake but are never stored
        push       = bus.lsu_valid && !fifo_full && (bus.lsu_addr != 6'd0);
        alu_win    = !stall_q && bus.alu_valid && (bus.alu_addr != 6'd0);
        pop        = !fifo_empty && !alu_win;
        head_addr  = mem_addr_q[rd_ptr_q];
        head_data  = mem_data_q[rd_ptr_q];
    end

    // Next-state for FIFO bookkeeping, output register and starvation logic
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        vld_d     = vld_q;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        starve_d  = starve_q;

        if (push) begin
            wr_ptr_d        = wr_ptr_q + 1'b1;
            vld_d[wr_ptr_q] = 1'b1;
        end
        if (pop) begin
            rd_ptr_d        = rd_ptr_q + 1'b1;
            vld_d[rd_ptr_q] = 1'b0;
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        if (alu_win) begin
            wb_en_d   = 1'b1;
            wb_addr_d = bus.alu_addr;
            wb_data_d = bus.alu_data;
        end else if (pop) begin
            wb_en_d   = 1'b1;
            wb_addr_d = head_addr;
            wb_data_d = head_data;
        end

        // Counts only ALU wins that leave a waiting LSU result behind
        if (pop || fifo_empty) begin
            starve_d = 4'd0;
        end else if (alu_win) begin
            starve_d = starve_q + 4'd1;
        end

        // Stall lands in the cycle right after the limit is reached; that
        // cycle pops (FIFO is non-empty) and so clears the counter again.
        stall_d = (starve_d == 4'(STARVE_LIMIT));
    end

    // Control state; reset discards queued results and drops the write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            vld_q     <= '0;
            starve_q  <= 4'd0;
            stall_q   <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= 6'd0;
            wb_data_q <= 32'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            vld_q     <= vld_d;
            starve_q  <= starve_d;
            stall_q   <= stall_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    // FIFO payload storage; contents are qualified by vld_q so need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_q[wr_ptr_q] <= bus.lsu_addr;
            mem_data_q[wr_ptr_q] <= bus.lsu_data;
        end
    end

    // Hazard lookup against every queued entry and the in-flight write
    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        rd_hit  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (mem_addr_q[i] == bus.rs1_addr)) rs1_hit = 1'b1;
            if (vld_q[i] && (mem_addr_q[i] == bus.rs2_addr)) rs2_hit = 1'b1;
            if (vld_q[i] && (mem_addr_q[i] == bus.rd_addr))  rd_hit  = 1'b1;
        end
        if (wb_en_q && (wb_addr_q == bus.rs1_addr)) rs1_hit = 1'b1;
        if (wb_en_q && (wb_addr_q == bus.rs2_addr)) rs2_hit = 1'b1;
        if (wb_en_q && (wb_addr_q == bus.rd_addr))  rd_hit  = 1'b1;
    end

    assign bus.rs1_pending = rs1_hit && (bus.rs1_addr != 6'd0);
    assign bus.rs2_pending = rs2_hit && (bus.rs2_addr != 6'd0);
    assign bus.rd_pending  = rd_hit  && (bus.rd_addr  != 6'd0);

    assign bus.alu_stall   = stall_q;
    assign bus.lsu_ready   = !fifo_full;
    assign bus.wb_en       = wb_en_q;
    assign bus.wb_addr     = wb_addr_q;
    assign bus.write_data  = wb_data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes are queued as stimulus is
// driven and checked in order by a monitor whenever wb_en is observed.
module tb_wb_arbiter;

    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    wr_t  exp_q[$];
    wr_t  lsu_hold[$];

    wb_arbiter_if bus ();

    wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic [5:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every observed write must match the oldest expectation
    always @(negedge clk) begin
        if (bus.wb_en === 1'b1) begin
            n_assert++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL wb_unexpected: observed write addr %h expected no write", bus.wb_addr);
            end
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("sb_wb_addr", 32'(bus.wb_addr), 32'(e.a));
                chk("sb_write_data", bus.write_data, e.d);
            end
        end
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.alu_valid = 1'b0; bus.alu_addr = 6'd0; bus.alu_data = 32'd0;
        bus.lsu_valid = 1'b0; bus.lsu_addr = 6'd0; bus.lsu_data = 32'd0;
        bus.rs1_addr = 6'd1; bus.rs2_addr = 6'd2; bus.rd_addr = 6'd3;
        #1;
        // Reset values
        chk("rst_wb_en", 32'(bus.wb_en), 32'd0);
        chk("rst_wb_addr", 32'(bus.wb_addr), 32'd0);
        chk("rst_write_data", bus.write_data, 32'd0);
        chk("rst_alu_stall", 32'(bus.alu_stall), 32'd0);
        chk("rst_lsu_ready", 32'(bus.lsu_ready), 32'd1);
        chk("rst_rs1_pending", 32'(bus.rs1_pending), 32'd0);
        chk("rst_rs2_pending", 32'(bus.rs2_pending), 32'd0);
        chk("rst_rd_pending", 32'(bus.rd_pending), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // ALU only: one-cycle latency, then an x0 ALU result writes nothing
        bus.alu_valid = 1'b1; bus.alu_addr = 6'd5; bus.alu_data = 32'hDEADBEEF;
        exp_push(6'd5, 32'hDEADBEEF);
        tick();
        chk("alu_wb_en", 32'(bus.wb_en), 32'd1);
        chk("alu_wb_addr", 32'(bus.wb_addr), 32'd5);
        chk("alu_write_data", bus.write_data, 32'hDEADBEEF);
        bus.alu_addr = 6'd0; bus.alu_data = 32'h00001234;
        tick();
        chk("alu_x0_wb_en", 32'(bus.wb_en), 32'd0);
        chk("alu_x0_hold_addr", 32'(bus.wb_addr), 32'd5);
        chk("alu_x0_hold_data", bus.write_data, 32'hDEADBEEF);
        bus.alu_valid = 1'b0;
        tick();

        // LSU minimum latency with ALU idle: two cycles
        bus.lsu_valid = 1'b1; bus.lsu_addr = 6'd7; bus.lsu_data = 32'h00000077;
        exp_push(6'd7, 32'h00000077);
        tick();
        bus.lsu_valid = 1'b0;
        chk("lsu_lat_cyc1_wb_en", 32'(bus.wb_en), 32'd0);
        tick();
        chk("lsu_lat_cyc2_wb_en", 32'(bus.wb_en), 32'd1);
        chk("lsu_lat_cyc2_addr", 32'(bus.wb_addr), 32'd7);
        tick();
        chk("lsu_lat_idle", 32'(bus.wb_en), 32'd0);

        // LSU fill while ALU holds the port, then in-order drain
        bus.rd_addr = 6'd3;
        for (int k = 0; k < 4; k++) begin
            wr_t h;
            bus.alu_valid = 1'b1; bus.alu_addr = 6'(20 + k); bus.alu_data = 32'hA000 + 32'(k);
            bus.lsu_valid = 1'b1; bus.lsu_addr = 6'(k + 1);  bus.lsu_data = 32'h100 + 32'(k + 1);
            chk("fill_ready_before_push", 32'(bus.lsu_ready), 32'd1);
            exp_push(bus.alu_addr, bus.alu_data);
            h.a = bus.lsu_addr; h.d = bus.lsu_data;
            lsu_hold.push_back(h);
            tick();
            chk("fill_rd_pending3", 32'(bus.rd_pending), (k >= 2) ? 32'd1 : 32'd0);
        end
        chk("fill_full_ready", 32'(bus.lsu_ready), 32'd0);
        bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
        while (lsu_hold.size() > 0) exp_q.push_back(lsu_hold.pop_front());
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) chk("drain_ready_after_pop", 32'(bus.lsu_ready), 32'd1);
            chk("drain_order_addr", 32'(bus.wb_addr), 32'(k + 1));
            chk("drain_rd_pending3", 32'(bus.rd_pending), (k <= 2) ? 32'd1 : 32'd0);
        end
        tick();
        chk("drain_done_wb_en", 32'(bus.wb_en), 32'd0);

        // Priority and starvation: 8 ALU wins, one stall slot drains addr 9
        bus.lsu_valid = 1'b1; bus.lsu_addr = 6'd9; bus.lsu_data = 32'h00000099;
        tick();
        bus.lsu_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.alu_valid = 1'b1; bus.alu_addr = 6'(10 + k); bus.alu_data = 32'hC000 + 32'(k);
            chk("starve_no_stall", 32'(bus.alu_stall), 32'd0);
            exp_push(bus.alu_addr, bus.alu_data);
            tick();
        end
        chk("starve_stall", 32'(bus.alu_stall), 32'd1);
        chk("starve_8th_alu", 32'(bus.wb_addr), 32'd17);
        bus.alu_addr = 6'd18; bus.alu_data = 32'h0000C018;
        exp_push(6'd9, 32'h00000099);
        exp_push(6'd18, 32'h0000C018);
        tick();
        chk("starve_drain_addr", 32'(bus.wb_addr), 32'd9);
        chk("starve_stall_one_cycle", 32'(bus.alu_stall), 32'd0);
        tick();
        chk("starve_alu_resume", 32'(bus.wb_addr), 32'd18);
        bus.alu_valid = 1'b0;
        tick();

        // x0 filtering on the LSU path
        bus.lsu_valid = 1'b1; bus.lsu_addr = 6'd0; bus.lsu_data = 32'h00000BAD;
        chk("x0_ready", 32'(bus.lsu_ready), 32'd1);
        tick();
        bus.lsu_valid = 1'b0;
        bus.rs1_addr = 6'd0; bus.rs2_addr = 6'd0; bus.rd_addr = 6'd0;
        #1;
        chk("x0_rs1_pending", 32'(bus.rs1_pending), 32'd0);
        chk("x0_rd_pending", 32'(bus.rd_pending), 32'd0);
        tick();
        chk("x0_no_write", 32'(bus.wb_en), 32'd0);
        chk("x0_ready_after", 32'(bus.lsu_ready), 32'd1);

        // FP address; an x0 ALU result leaves the slot to the FIFO
        bus.lsu_valid = 1'b1; bus.lsu_addr = 6'h25; bus.lsu_data = 32'h25252525;
        exp_push(6'h25, 32'h25252525);
        tick();
        bus.lsu_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_addr = 6'd0; bus.alu_data = 32'hFFFFFFFF;
        bus.rs1_addr = 6'h25; bus.rs2_addr = 6'h05;
        #1;
        chk("fp_rs1_pending_q", 32'(bus.rs1_pending), 32'd1);
        chk("fp_rs2_pending_q", 32'(bus.rs2_pending), 32'd0);
        tick();
        chk("fp_wb_addr", 32'(bus.wb_addr), 32'h25);
        chk("fp_rs1_pending_wb", 32'(bus.rs1_pending), 32'd1);
        bus.alu_valid = 1'b0;
        tick();
        chk("fp_rs1_pending_gone", 32'(bus.rs1_pending), 32'd0);
        chk("fp_idle", 32'(bus.wb_en), 32'd0);

        // Reset mid-stream with 3 queued entries and a write in flight
        bus.rd_addr = 6'd51;
        for (int k = 0; k < 3; k++) begin
            bus.alu_valid = 1'b1; bus.alu_addr = 6'(40 + k); bus.alu_data = 32'hE000 + 32'(k);
            bus.lsu_valid = 1'b1; bus.lsu_addr = 6'(50 + k); bus.lsu_data = 32'hF000 + 32'(k);
            exp_push(bus.alu_addr, bus.alu_data);
            tick();
        end
        chk("midrst_wb_en_before", 32'(bus.wb_en), 32'd1);
        chk("midrst_pending_before", 32'(bus.rd_pending), 32'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
        #1;
        chk("midrst_wb_en", 32'(bus.wb_en), 32'd0);
        chk("midrst_wb_addr", 32'(bus.wb_addr), 32'd0);
        chk("midrst_write_data", bus.write_data, 32'd0);
        chk("midrst_alu_stall", 32'(bus.alu_stall), 32'd0);
        chk("midrst_lsu_ready", 32'(bus.lsu_ready), 32'd1);
        chk("midrst_rd_pending", 32'(bus.rd_pending), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_rst_no_write", 32'(bus.wb_en), 32'd0);
        end
        chk("post_rst_pending", 32'(bus.rd_pending), 32'd0);
        chk("sb_empty_at_end", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
